// File: rtl/pwm_mc.sv
// pwm_mc: multi-channel PWM generator driven by one shared counter.
// One prescaler and one counter serve every channel. The counter runs edge-aligned (saw-tooth)
// or center-aligned (triangle). Duty values are double-buffered. A write lands in the shadow
// copy, and every shadow copy is moved into the active copy at the period boundary.
module pwm_mc #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESC_W  = 8,
   parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                i_clk,
   input  logic                i_resetb,
   input  logic [PRESC_W-1:0]  i_prescale,
   input  logic                i_center_mode,
   input  logic [CHANNELS-1:0] i_ch_en,
   input  logic                i_wr_en,
   input  logic [CH_W-1:0]     i_wr_ch,
   input  logic [WIDTH-1:0]    i_wr_duty,
   output logic [CHANNELS-1:0] o_pwm_out,
   output logic                o_period_start,
   output logic [WIDTH-1:0]    o_cnt_mon
);

   localparam logic [WIDTH-1:0]   LP_MAX    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   LP_ONE    = WIDTH'(1);
   localparam logic [PRESC_W-1:0] LP_P_ONE  = PRESC_W'(1);
   // One extra bit so that CHANNELS itself fits when it is a power of two.
   localparam logic [CH_W:0]      LP_CH_LIM = (CH_W + 1)'(CHANNELS);

   typedef enum logic {
      DirUp,
      DirDown
   } dir_e;

   // State
   logic [PRESC_W-1:0]  r_presc_cnt;
   logic [WIDTH-1:0]    r_cnt;
   dir_e                r_dir;
   logic                r_mode_active;
   logic [WIDTH-1:0]    r_shadow [CHANNELS];
   logic [WIDTH-1:0]    r_active [CHANNELS];
   logic [CHANNELS-1:0] r_pwm;
   logic                r_period_start;

   // Next-state
   logic                w_tick;
   logic [PRESC_W-1:0]  w_presc_d;
   logic [WIDTH-1:0]    w_cnt_d;
   dir_e                w_dir_d;
   logic                w_boundary;
   logic                w_wr_ok;
   logic [WIDTH-1:0]    w_shadow_d [CHANNELS];
   logic [CHANNELS-1:0] w_pwm_d;

   // Prescaler: the >= compare makes a lowered prescale take effect without a long wrap.
   always_comb begin
      w_tick    = (r_presc_cnt >= i_prescale);
      w_presc_d = w_tick ? '0 : r_presc_cnt + LP_P_ONE;
   end

   // Counter and direction next-state; the boundary is the tick on which cnt becomes 0.
   always_comb begin
      w_cnt_d    = r_cnt;
      w_dir_d    = r_dir;
      w_boundary = 1'b0;
      if (w_tick) begin
         if (!r_mode_active) begin
            w_cnt_d    = r_cnt + LP_ONE;
            w_boundary = (r_cnt == LP_MAX);
         end else begin
            case (r_dir)
               DirUp: begin
                  if (r_cnt == LP_MAX) begin
                     w_cnt_d = r_cnt - LP_ONE;
                     w_dir_d = DirDown;
                  end else begin
                     w_cnt_d = r_cnt + LP_ONE;
                  end
               end
               DirDown: begin
                  // <= rather than == so a stray 0 while counting down still ends the period.
                  if (r_cnt <= LP_ONE) begin
                     w_cnt_d    = '0;
                     w_boundary = 1'b1;
                  end else begin
                     w_cnt_d = r_cnt - LP_ONE;
                  end
               end
               default: begin
                  w_dir_d = DirUp;
               end
            endcase
         end
         if (w_boundary) begin
            w_dir_d = DirUp;
         end
      end
   end

   // Shadow next-state; out-of-range channel indices are dropped.
   always_comb begin
      w_wr_ok = i_wr_en && ({1'b0, i_wr_ch} < LP_CH_LIM);
      for (int ch = 0; ch < CHANNELS; ch++) begin
         w_shadow_d[ch] = r_shadow[ch];
         if (w_wr_ok && (i_wr_ch == CH_W'(ch))) begin
            w_shadow_d[ch] = i_wr_duty;
         end
      end
   end

   // Per-channel compare against the registered counter; pwm therefore lags cnt_mon by one clk.
   always_comb begin
      w_pwm_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         w_pwm_d[ch] = i_ch_en[ch] & (r_cnt < r_active[ch]);
      end
   end

   // Prescaler, counter, direction and mode registers.
   always_ff @(posedge i_clk) begin
      if (!i_resetb) begin
         r_presc_cnt    <= '0;
         r_cnt          <= '0;
         r_dir          <= DirUp;
         r_mode_active  <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_presc_cnt    <= w_presc_d;
         r_cnt          <= w_cnt_d;
         r_dir          <= w_dir_d;
         r_period_start <= w_boundary;
         if (w_boundary) begin
            r_mode_active <= i_center_mode;
         end
      end
   end

   // Duty double buffer. The shadow next-state feeds active, so a boundary write bypasses.
   always_ff @(posedge i_clk) begin
      if (!i_resetb) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_shadow[ch] <= '0;
            r_active[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_shadow[ch] <= w_shadow_d[ch];
            if (w_boundary) begin
               r_active[ch] <= w_shadow_d[ch];
            end
         end
      end
   end

   // Registered PWM outputs.
   always_ff @(posedge i_clk) begin
      if (!i_resetb) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= w_pwm_d;
      end
   end

   assign o_pwm_out      = r_pwm;
   assign o_period_start = r_period_start;
   assign o_cnt_mon      = r_cnt;

endmodule
